// File: rtl/arm_alu_pipe.sv
// rtl/arm_alu_pipe.sv - registered ARM data-processing ALU with NZCV flags and optional shift-add multiplier
//
// Executes the 16 ARM data-processing opcodes in one cycle and, when the
// ARM_ALU_PIPE_MUL_EN macro is defined, MUL/MLA as a WIDTH-iteration radix-2
// shift-add. Without the macro a multiply request completes in one cycle
// flagged ill with result 0 and wr_en 0.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid / in_ready        request handshake
//   opcode, mul, acc, s_bit    operation select (mul+acc = MLA), flag update
//   A, B, C_op, shift_carry    operands, accumulator, shifter carry-out
//   out_valid / out_ready      result handshake
//   result, wr_en, ill         registered result, writeback enable, unsupported op
//   N, Z, C, V                 architectural flag register
module arm_alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic             mul,
  input  logic             acc,
  input  logic             s_bit,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C_op,
  input  logic             shift_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V,
  output logic             wr_en,
  output logic             ill
);

  localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
                         OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
                         OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
                         OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF;

  logic [WIDTH-1:0] x, y, logic_res, alu_res;
  logic [WIDTH:0]   sum;
  logic             cin, arith, alu_c, alu_v, alu_wr, alu_fw;
  logic             accept, load_alu, load_mul;

  // Subtractions become x + ~y + cin so one adder covers every arithmetic op
  // and its carry-out is directly the ARM "not borrow" C flag.
  always_comb begin
    x         = A;
    y         = B;
    cin       = 1'b0;
    arith     = 1'b1;
    logic_res = '0;
    case (opcode)
      OP_SUB, OP_CMP: begin y = ~B; cin = 1'b1; end
      OP_RSB:         begin x = B; y = ~A; cin = 1'b1; end
      OP_ADC:         cin = C;
      OP_SBC:         begin y = ~B; cin = C; end
      OP_RSC:         begin x = B; y = ~A; cin = C; end
      OP_ADD, OP_CMN: cin = 1'b0;
      default:        arith = 1'b0;
    endcase
    case (opcode)
      OP_AND, OP_TST: logic_res = A & B;
      OP_EOR, OP_TEQ: logic_res = A ^ B;
      OP_ORR:         logic_res = A | B;
      OP_MOV:         logic_res = B;
      OP_BIC:         logic_res = A & ~B;
      OP_MVN:         logic_res = ~B;
      default:        logic_res = '0;
    endcase
  end

  assign sum     = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
  assign alu_res = arith ? sum[WIDTH-1:0] : logic_res;
  assign alu_c   = arith ? sum[WIDTH] : shift_carry;
  assign alu_v   = arith ? ((x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1])) : V;
  // TST/TEQ/CMP/CMN (8..B) never write back but always update flags.
  assign alu_wr  = (opcode[3:2] != 2'b10);
  assign alu_fw  = s_bit || !alu_wr;

  assign accept   = in_valid && in_ready;
  assign load_alu = accept && !mul;

`ifdef ARM_ALU_PIPE_MUL_EN
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand, mplier, prod;
  logic             mul_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (accept && mul) state_n = S_MUL;
      S_MUL:   if (cnt == CW'(WIDTH - 1)) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
  // The output register is always free in DONE: entering MUL required it to
  // be empty or retiring, and nothing else can load it while busy.
  assign load_mul = (state == S_DONE);

  // Product starts at the accumulator so MLA costs no extra cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      mul_s  <= 1'b0;
    end else if (accept && mul) begin
      cnt    <= '0;
      mcand  <= A;
      mplier <= B;
      prod   <= acc ? C_op : '0;
      mul_s  <= s_bit;
    end else if (state == S_MUL) begin
      if (mplier[0]) prod <= prod + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end
`else
  logic unused_mul_ok;
  assign unused_mul_ok = ^{acc, C_op};
  assign in_ready      = !out_valid || out_ready;
  assign load_mul      = accept && mul;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result    <= '0;
      wr_en     <= 1'b0;
      ill       <= 1'b0;
      out_valid <= 1'b0;
      {N, Z, C, V} <= 4'b0000;
    end else if (load_alu) begin
      result    <= alu_res;
      wr_en     <= alu_wr;
      ill       <= 1'b0;
      out_valid <= 1'b1;
      if (alu_fw) {N, Z, C, V} <= {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
    end else if (load_mul) begin
      out_valid <= 1'b1;
`ifdef ARM_ALU_PIPE_MUL_EN
      result    <= prod;
      wr_en     <= 1'b1;
      ill       <= 1'b0;
      if (mul_s) {N, Z} <= {prod[WIDTH-1], (prod == '0)};
`else
      result    <= '0;
      wr_en     <= 1'b0;
      ill       <= 1'b1;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
